close_path_arbiter: RTL
=======================

# close_path_arbiter

Shares one close-path mantissa datapath (the |Ea−Eb| < 2 subtract unit of the dual-path FP adder) between two independent requesters. It arbitrates round-robin, issues at most one operation per cycle into the fixed-latency datapath, and tracks the owner of every in-flight operation. Results are steered into per-requester response FIFOs with valid/ready handshakes. Credit counters guarantee a result always has FIFO space when it emerges, so the datapath never stalls.

## Interface
- size_mantissa, 24, mantissa width including hidden bit
- size_exponent, 8, exponent width; exp_inter is size_exponent+1 bits
- latency, 2, datapath pipeline depth in cycles, ≥ 0; 0 = combinational
- fifo_depth, 4, response FIFO entries per requester (power of two, ≥ 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- reqN_valid  in  1  requester N (N = 0,1) operation present
- reqN_ready  out  1  operation accepted this cycle
- reqN_m_a, reqN_m_b  in  size_mantissa  mantissas (a is the larger-exponent operand)
- reqN_exp_inter  in  size_exponent+1  intermediate exponent
- reqN_exp_diff  in  1  1 = exponents differ by one
- dp_m_a, dp_m_b  out  size_mantissa  datapath operands
- dp_exp_inter  out  size_exponent+1  datapath exponent
- dp_exp_difference  out  1  datapath exponent-difference flag
- dp_issue  out  1  datapath inputs valid this cycle
- dp_m_o  in  size_mantissa  datapath result mantissa, `latency` cycles after issue
- dp_e_o  in  size_exponent  datapath result exponent
- dp_ovf  in  1  datapath sign-swap flag
- rspN_valid  out  1  result available for requester N
- rspN_ready  in  1  requester N consumes result
- rspN_m  out  size_mantissa  result mantissa
- rspN_e  out  size_exponent  result exponent
- rspN_ovf  out  1  result swap flag

## Operation
- **Credits.** Per requester, width clog2(fifo_depth+1), reset to fifo_depth.
  - Decrement on accept; increment on rspN pop (rspN_valid & rspN_ready).
  - Both in the same cycle: unchanged.
- **Eligibility.** eligN = reqN_valid & (creditN ≠ 0).
- **Arbitration.** Round-robin pointer `last` (1 bit) names the last granted requester and resets to 1, so requester 0 wins the first tie.
  - Only one eligible: it is granted.
  - Both eligible: the requester ≠ last is granted.
  - `last` updates only on a grant.
- **Ready.** reqN_ready = grantN, combinational from valid and credit state. At most one ready per cycle.
- **Issue.**
  - On grant: dp_issue = 1 and the dp_* operand outputs carry the granted requester's fields, combinationally muxed.
  - With no grant: dp_issue = 0 and all dp_* operand outputs are 0.
- **Tag pipeline.** `latency` stages of {valid, id}, shifting every cycle. Stage 0 is loaded with {dp_issue, granted id}.
  - latency = 0: the tag is used in the same cycle.
  - When the tag exits with valid = 1, {dp_m_o, dp_e_o, dp_ovf} is written to FIFO[id] on that edge.
- **Response FIFOs.**
  - rspN_* fields show the FIFO head; rspN_valid = FIFO non-empty.
  - Write and pop may occur in the same cycle.
  - Credits make write-when-full impossible. The implementation must include an assertion flagging that case.
- **Reset.** Asserting rst at any time, including with operations in flight:
  - clears all tag valids and both FIFOs;
  - restores credits and `last`;
  - discards in-flight results.

## Timing
- Reset values:
  - reqN_ready = 0, dp_issue = 0, rspN_valid = 0.
  - dp_* operands = 0; rspN_m/e/ovf = 0 (empty-FIFO head reads as zero).
- Accept in cycle t → FIFO write at the edge ending cycle t+latency → rspN_valid high in cycle t+latency+1.
- Throughput: one issue per cycle total across both requesters.
- A single requester with rspN_ready held high sustains one operation per cycle when fifo_depth ≥ latency+2. Smaller fifo_depth throttles issue by credits only; results stay correct.
- A pop in cycle t frees the credit for an accept in cycle t+1, not in cycle t.
- FIFO ordering is per requester, oldest first. No ordering holds between requesters.

## Test plan
- **Reset and first tie.** Hold rst mid-stream with two ops in flight, then release, then raise both valids. Required: rsp*_valid = 0 and credits = 4 after reset. Requester 0 is granted first, then requester 1, alternating.
- **Single stream, latency = 2.** req0 issues m_a = 0xC00000, m_b = 0x800000, exp_inter = 0x081, exp_diff = 0 in cycle 5. Required: dp_* carries these values in cycle 5 and rsp0_valid rises in cycle 8 with the datapath's result. rsp1_valid stays 0.
- **Credit exhaustion.** rsp0_ready = 0 and req0_valid held high. Required: exactly 4 accepts, then req0_ready = 0. One pop in cycle t gives exactly one more accept, in cycle t+1.
- **Interleave and ordering.** Both requesters stream 8 ops each with random rspN_ready stalls. Required: every result reaches its owner in issue order, with no loss and no duplication. Grants alternate whenever both requesters are eligible.
- **Simultaneous events.** Same cycle: FIFO0 write, FIFO0 pop, and a req0 accept. Required: FIFO0 occupancy unchanged, credit0 unchanged, no full assertion.
- **latency = 0 build.** Accept in cycle t. Required: rsp valid in cycle t+1 with full-rate streaming.

Source files
------------

// File: rtl/close_path_arbiter.sv
// Round-robin sharing of one fixed-latency close-path mantissa datapath between two
// requesters, with owner-tag pipeline, per-requester response FIFOs and credit flow control.
module close_path_arbiter #(
    parameter int unsigned size_mantissa = 24,
    parameter int unsigned size_exponent = 8,
    parameter int unsigned latency       = 2,
    parameter int unsigned fifo_depth    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [size_mantissa-1:0] req0_m_a,
    input  logic [size_mantissa-1:0] req0_m_b,
    input  logic [size_exponent:0]   req0_exp_inter,
    input  logic                     req0_exp_diff,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [size_mantissa-1:0] req1_m_a,
    input  logic [size_mantissa-1:0] req1_m_b,
    input  logic [size_exponent:0]   req1_exp_inter,
    input  logic                     req1_exp_diff,
    output logic [size_mantissa-1:0] dp_m_a,
    output logic [size_mantissa-1:0] dp_m_b,
    output logic [size_exponent:0]   dp_exp_inter,
    output logic                     dp_exp_difference,
    output logic                     dp_issue,
    input  logic [size_mantissa-1:0] dp_m_o,
    input  logic [size_exponent-1:0] dp_e_o,
    input  logic                     dp_ovf,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [size_mantissa-1:0] rsp0_m,
    output logic [size_exponent-1:0] rsp0_e,
    output logic                     rsp0_ovf,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [size_mantissa-1:0] rsp1_m,
    output logic [size_exponent-1:0] rsp1_e,
    output logic                     rsp1_ovf
);
    localparam int unsigned   CW         = $clog2(fifo_depth + 1);
    localparam int unsigned   AW         = $clog2(fifo_depth);
    localparam int unsigned   RW         = size_mantissa + size_exponent + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(fifo_depth);

    logic [1:0]    elig, grant, wr, pop;
    logic          gnt_id, last_q, last_d;
    logic [CW-1:0] credit_q [2];
    logic [CW-1:0] credit_d [2];
    logic          tag_v, tag_id;
    logic          nonempty [2];
    logic [RW-1:0] head [2];

    // Tie goes to the requester that was not granted last.
    always_comb begin
        elig[0] = req0_valid && (credit_q[0] != '0);
        elig[1] = req1_valid && (credit_q[1] != '0);
        if (elig == 2'b11) gnt_id = ~last_q;
        else               gnt_id = elig[1];
        grant = '0;
        if (elig != 2'b00) grant[gnt_id] = 1'b1;
        last_d = (elig != 2'b00) ? gnt_id : last_q;
        for (int unsigned g = 0; g < 2; g++)
            credit_d[g] = credit_q[g] + CW'(pop[g]) - CW'(grant[g]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q[0] <= CREDIT_MAX;
            credit_q[1] <= CREDIT_MAX;
            last_q      <= 1'b1;
        end else begin
            credit_q[0] <= credit_d[0];
            credit_q[1] <= credit_d[1];
            last_q      <= last_d;
        end
    end

    always_comb begin
        dp_issue          = (grant != 2'b00);
        dp_m_a            = '0;
        dp_m_b            = '0;
        dp_exp_inter      = '0;
        dp_exp_difference = 1'b0;
        if (grant[0]) begin
            dp_m_a            = req0_m_a;
            dp_m_b            = req0_m_b;
            dp_exp_inter      = req0_exp_inter;
            dp_exp_difference = req0_exp_diff;
        end else if (grant[1]) begin
            dp_m_a            = req1_m_a;
            dp_m_b            = req1_m_b;
            dp_exp_inter      = req1_exp_inter;
            dp_exp_difference = req1_exp_diff;
        end
    end

    if (latency == 0) begin : g_tag_comb
        assign tag_v  = dp_issue;
        assign tag_id = gnt_id;
    end else begin : g_tag_pipe
        logic [latency-1:0] v_q, id_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q  <= '0;
                id_q <= '0;
            end else begin
                v_q[0]  <= dp_issue;
                id_q[0] <= gnt_id;
                for (int unsigned i = 1; i < latency; i++) begin
                    v_q[i]  <= v_q[i-1];
                    id_q[i] <= id_q[i-1];
                end
            end
        end

        assign tag_v  = v_q[latency-1];
        assign tag_id = id_q[latency-1];
    end

    always_comb begin
        wr         = '0;
        wr[tag_id] = tag_v;
        pop        = {rsp1_ready & nonempty[1], rsp0_ready & nonempty[0]};
    end

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [RW-1:0] mem_q [fifo_depth];
        logic [AW-1:0] wptr_q, rptr_q;
        logic [CW-1:0] count_q;

        always_ff @(posedge clk) begin
            if (wr[g]) mem_q[wptr_q] <= {dp_m_o, dp_e_o, dp_ovf};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (wr[g])  wptr_q <= wptr_q + AW'(1);
                if (pop[g]) rptr_q <= rptr_q + AW'(1);
                count_q <= count_q + CW'(wr[g]) - CW'(pop[g]);
            end
        end

        // Empty FIFO presents an all-zero head.
        assign nonempty[g] = (count_q != '0);
        assign head[g]     = nonempty[g] ? mem_q[rptr_q] : '0;

        a_no_write_when_full: assert property (@(posedge clk) disable iff (rst)
            !(wr[g] && (count_q == CREDIT_MAX)));
    end

    assign req0_ready                   = grant[0];
    assign req1_ready                   = grant[1];
    assign rsp0_valid                   = nonempty[0];
    assign rsp1_valid                   = nonempty[1];
    assign {rsp0_m, rsp0_e, rsp0_ovf}   = head[0];
    assign {rsp1_m, rsp1_e, rsp1_ovf}   = head[1];
endmodule
